// File: rtl/systolic_array_mxn.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_mxn
// Purpose  : Output-stationary ROWSxCOLS systolic matrix multiplier.
//            Takes one A/B tile beat and returns C = A*B or C += A*B.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_array_mxn #(
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 9,
    parameter int ROWS       = 2,
    parameter int COLS       = 2,
    parameter int K          = 2,
    parameter bit SIGNED     = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            acc_en,
    input  logic [ROWS*K*DATA_WIDTH-1:0]    a_flat,
    input  logic [K*COLS*DATA_WIDTH-1:0]    b_flat,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ROWS*COLS*ACC_WIDTH-1:0]  c_flat,
    output logic                            busy
);

    localparam int c_T  = K + ROWS + COLS - 2;
    localparam int c_TW = (c_T > 1) ? $clog2(c_T) : 1;
    localparam int c_PW = (2 * DATA_WIDTH > ACC_WIDTH) ? 2 * DATA_WIDTH : ACC_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                 state_q;
    logic [c_TW-1:0]        t_q;
    logic [DATA_WIDTH-1:0]  a_q    [ROWS][K];
    logic [DATA_WIDTH-1:0]  b_q    [K][COLS];
    logic [DATA_WIDTH-1:0]  ah_q   [ROWS][COLS];
    logic [DATA_WIDTH-1:0]  bv_q   [ROWS][COLS];
    logic [ACC_WIDTH-1:0]   acc_q  [ROWS][COLS];
    logic [DATA_WIDTH-1:0]  a_edge_d [ROWS];
    logic [DATA_WIDTH-1:0]  b_edge_d [COLS];
    logic                   w_accept;

    // Widening before the multiply keeps the low ACC_WIDTH bits correct for both signednesses.
    function automatic logic [c_PW-1:0] f_ext(input logic [DATA_WIDTH-1:0] v);
        if (SIGNED)
            return {{(c_PW-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
        return {{(c_PW-DATA_WIDTH){1'b0}}, v};
    endfunction

    assign in_ready  = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_COMPUTE);

    // Edge feeders present the operand needed at the next step (t+1), skewed by row/column.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            a_edge_d[i] = '0;
            for (int k = 0; k < K; k++)
                if (int'(t_q) + 1 - i == k) a_edge_d[i] = a_q[i][k];
        end
        for (int j = 0; j < COLS; j++) begin
            b_edge_d[j] = '0;
            for (int k = 0; k < K; k++)
                if (int'(t_q) + 1 - j == k) b_edge_d[j] = b_q[k][j];
        end
    end

    always_comb begin
        c_flat = '0;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                c_flat[(i*COLS+j)*ACC_WIDTH +: ACC_WIDTH] = acc_q[i][j];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            for (int i = 0; i < ROWS; i++)
                for (int k = 0; k < K; k++) a_q[i][k] <= '0;
            for (int k = 0; k < K; k++)
                for (int j = 0; j < COLS; j++) b_q[k][j] <= '0;
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    ah_q[i][j]  <= '0;
                    bv_q[i][j]  <= '0;
                    acc_q[i][j] <= '0;
                end
        end else if (w_accept) begin
            state_q <= S_COMPUTE;
            t_q     <= '0;
            for (int i = 0; i < ROWS; i++)
                for (int k = 0; k < K; k++)
                    a_q[i][k] <= a_flat[(i*K+k)*DATA_WIDTH +: DATA_WIDTH];
            for (int k = 0; k < K; k++)
                for (int j = 0; j < COLS; j++)
                    b_q[k][j] <= b_flat[(k*COLS+j)*DATA_WIDTH +: DATA_WIDTH];
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    ah_q[i][j] <= '0;
                    bv_q[i][j] <= '0;
                    if (!acc_en) acc_q[i][j] <= '0;
                end
            // Step 0 only has work at the corner PE.
            ah_q[0][0] <= a_flat[DATA_WIDTH-1:0];
            bv_q[0][0] <= b_flat[DATA_WIDTH-1:0];
        end else begin
            case (state_q)
                S_COMPUTE: begin
                    for (int i = 0; i < ROWS; i++)
                        for (int j = 0; j < COLS; j++)
                            acc_q[i][j] <= acc_q[i][j]
                                + ACC_WIDTH'(f_ext(ah_q[i][j]) * f_ext(bv_q[i][j]));
                    for (int i = 0; i < ROWS; i++) begin
                        ah_q[i][0] <= a_edge_d[i];
                        for (int j = 1; j < COLS; j++) ah_q[i][j] <= ah_q[i][j-1];
                    end
                    for (int j = 0; j < COLS; j++) begin
                        bv_q[0][j] <= b_edge_d[j];
                        for (int i = 1; i < ROWS; i++) bv_q[i][j] <= bv_q[i-1][j];
                    end
                    if (t_q == c_TW'(c_T - 1))
                        state_q <= S_DONE;
                    else
                        t_q <= t_q + 1'b1;
                end
                S_DONE: begin
                    if (out_ready) state_q <= S_IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_mxn.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_array_mxn
// Purpose  : Directed self-checking bench for systolic_array_mxn.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_array_mxn;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // 2x2x2 unsigned
    logic        in_valid, in_ready, acc_en, out_valid, out_ready, busy;
    logic [15:0] a_flat, b_flat;
    logic [35:0] c_flat;
    // 2x2x2 signed
    logic        s_in_valid, s_in_ready, s_acc_en, s_out_valid, s_out_ready, s_busy;
    logic [15:0] s_a_flat, s_b_flat;
    logic [35:0] s_c_flat;
    // 3x2x4 unsigned
    logic        r_in_valid, r_in_ready, r_acc_en, r_out_valid, r_out_ready, r_busy;
    logic [47:0] r_a_flat;
    logic [31:0] r_b_flat;
    logic [53:0] r_c_flat;

    int total = 0;
    int bad   = 0;

    systolic_array_mxn #(.DATA_WIDTH(4), .ACC_WIDTH(9), .ROWS(2), .COLS(2), .K(2), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .acc_en(acc_en),
        .a_flat(a_flat), .b_flat(b_flat), .out_valid(out_valid), .out_ready(out_ready),
        .c_flat(c_flat), .busy(busy));

    systolic_array_mxn #(.DATA_WIDTH(4), .ACC_WIDTH(9), .ROWS(2), .COLS(2), .K(2), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .acc_en(s_acc_en),
        .a_flat(s_a_flat), .b_flat(s_b_flat), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .c_flat(s_c_flat), .busy(s_busy));

    systolic_array_mxn #(.DATA_WIDTH(4), .ACC_WIDTH(9), .ROWS(3), .COLS(2), .K(4), .SIGNED(1'b0)) u_rect (
        .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready), .acc_en(r_acc_en),
        .a_flat(r_a_flat), .b_flat(r_b_flat), .out_valid(r_out_valid), .out_ready(r_out_ready),
        .c_flat(r_c_flat), .busy(r_busy));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] p4(input logic [3:0] x00, x01, x10, x11);
        return {x11, x10, x01, x00};
    endfunction

    function automatic logic [35:0] p9(input logic [8:0] x00, x01, x10, x11);
        return {x11, x10, x01, x00};
    endfunction

    // Accept one job on the 2x2 unsigned array, check latency/busy/result, then drain.
    task automatic job0(input logic [15:0] a, input logic [15:0] b, input logic acc,
                        input logic [35:0] exp, input string tag);
        int n, nb;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_flat    = a;
        b_flat    = b;
        acc_en    = acc;
        step();
        in_valid = 1'b0;
        a_flat   = '1;
        b_flat   = '1;
        acc_en   = 1'b0;
        n  = 0;
        nb = 0;
        while (!out_valid && n < 20) begin
            if (busy) nb++;
            step();
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'd4);
        chk({tag, " busy cycles"}, 64'(nb), 64'd4);
        chk({tag, " c_flat"}, 64'(c_flat), 64'(exp));
        step();
    endtask

    localparam logic [15:0] c_A_BASIC = 16'h4321;  // [[1,2],[3,4]]
    localparam logic [15:0] c_B_BASIC = 16'h8765;  // [[5,6],[7,8]]

    initial begin
        int n, nb;
        int e_rect [6] = '{2, 2, 4, 6, 0, 1};

        rst = 1'b1;
        in_valid = 1'b0; acc_en = 1'b0; a_flat = '0; b_flat = '0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_acc_en = 1'b0; s_a_flat = '0; s_b_flat = '0; s_out_ready = 1'b1;
        r_in_valid = 1'b0; r_acc_en = 1'b0; r_a_flat = '0; r_b_flat = '0; r_out_ready = 1'b1;
        step();
        step();
        chk("reset in_ready", 64'(in_ready), 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset c_flat", 64'(c_flat), 64'd0);
        rst = 1'b0;
        #1;
        chk("post-reset in_ready", 64'(in_ready), 64'd1);
        chk("post-reset s_in_ready", 64'(s_in_ready), 64'd1);

        job0(c_A_BASIC, c_B_BASIC, 1'b0, p9(9'd19, 9'd22, 9'd43, 9'd50), "basic");
        job0(c_A_BASIC, c_B_BASIC, 1'b1, p9(9'd38, 9'd44, 9'd86, 9'd100), "accum");
        job0(16'hFFFF, 16'hFFFF, 1'b0, p9(9'd450, 9'd450, 9'd450, 9'd450), "all15");
        job0(16'hFFFF, 16'hFFFF, 1'b1, p9(9'd388, 9'd388, 9'd388, 9'd388), "wrap");

        // Backpressure: result held while out_ready=0, pending beat ignored until ready.
        out_ready = 1'b0;
        in_valid  = 1'b1; a_flat = c_A_BASIC; b_flat = c_B_BASIC; acc_en = 1'b0;
        step();
        in_valid = 1'b0; a_flat = '1; b_flat = '1;
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        chk("bp latency", 64'(n), 64'd4);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a_flat   = p4(4'd2, 4'd0, 4'd0, 4'd2);
            b_flat   = p4(4'd1, 4'd2, 4'd3, 4'd4);
            step();
            chk($sformatf("bp stall%0d out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("bp stall%0d in_ready", i), 64'(in_ready), 64'd0);
            chk($sformatf("bp stall%0d c_flat", i), 64'(c_flat), 64'(p9(9'd19, 9'd22, 9'd43, 9'd50)));
        end
        out_ready = 1'b1;
        #1;
        chk("b2b in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0; a_flat = '1; b_flat = '1;
        chk("b2b busy", 64'(busy), 64'd1);
        chk("b2b out_valid", 64'(out_valid), 64'd0);
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        chk("b2b latency", 64'(n), 64'd4);
        chk("b2b c_flat", 64'(c_flat), 64'(p9(9'd2, 9'd4, 9'd6, 9'd8)));
        step();

        // Reset two cycles into a job.
        in_valid = 1'b1; a_flat = c_A_BASIC; b_flat = c_B_BASIC; acc_en = 1'b1;
        step();
        in_valid = 1'b0; acc_en = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst c_flat", 64'(c_flat), 64'd0);
        rst = 1'b0;
        job0(c_A_BASIC, c_B_BASIC, 1'b0, p9(9'd19, 9'd22, 9'd43, 9'd50), "after rst");

        // Signed: A=[[-1,2],[0,1]], B=[[3,0],[0,-2]].
        s_in_valid = 1'b1;
        s_a_flat   = p4(4'hF, 4'd2, 4'd0, 4'd1);
        s_b_flat   = p4(4'd3, 4'd0, 4'd0, 4'hE);
        step();
        s_in_valid = 1'b0; s_a_flat = '0; s_b_flat = '0;
        n = 0; nb = 0;
        while (!s_out_valid && n < 20) begin if (s_busy) nb++; step(); n++; end
        chk("signed latency", 64'(n), 64'd4);
        chk("signed busy cycles", 64'(nb), 64'd4);
        chk("signed c_flat", 64'(s_c_flat), 64'(p9(9'h1FD, 9'h1FC, 9'h000, 9'h1FE)));
        step();

        // Non-square 3x2x4.
        r_in_valid = 1'b1;
        r_a_flat   = 48'h1000_4321_1111;
        r_b_flat   = 32'h1001_1001;
        step();
        r_in_valid = 1'b0; r_a_flat = '1; r_b_flat = '1;
        n = 0; nb = 0;
        while (!r_out_valid && n < 30) begin if (r_busy) nb++; step(); n++; end
        chk("rect latency", 64'(n), 64'd7);
        chk("rect busy cycles", 64'(nb), 64'd7);
        for (int e = 0; e < 6; e++)
            chk($sformatf("rect c%0d", e), 64'(r_c_flat[e*9 +: 9]), 64'(e_rect[e]));
        chk("rect in_ready", 64'(r_in_ready), 64'd1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
